mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage; executes MULT, MULTU, DIV and DIVU.
- Takes its operands from the ID register-file read ports (rs value, rt value) through the ID/EX latch.
- Owns the architectural HI/LO registers and supports MTHI/MTLO writes.
- Exposes busy/done so the hazard unit can stall MFHI/MFLO and further mult/div issue.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each and the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue request; sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  WIDTH  rs value (multiplicand / dividend)
- operand_b  input  WIDTH  rt value (multiplier / divisor)
- abort  input  1  pipeline flush; cancels the in-flight operation
- mthi_en  input  1  write wr_data to HI
- mtlo_en  input  1  write wr_data to LO
- wr_data  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by a mult/div

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter and internal regs=0. A reset mid-operation discards the operation.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge E0: latch op and operand magnitudes. Signed ops use |a| and |b|, plus result-sign flags.
  - Go to CALC with count=0 and busy=1 after E0.
  - mthi_en/mtlo_en are honoured only in IDLE and only when start=0. start has priority; a simultaneous mthi/mtlo is dropped.
  - mthi_en and mtlo_en together both write.
- CALC: one iteration per cycle, WIDTH iterations (edges E1..E32 for WIDTH=32), then go to FIN.
  - Multiply: radix-2 shift-add on the 2*WIDTH accumulator.
  - Divide: restoring division; the remainder register is WIDTH+1 bits to hold the trial subtraction.
- FIN, at edge E33:
  - Apply sign correction and write HI/LO.
  - done=1 for exactly the cycle after E33; busy=0 after E33; return to IDLE.
  - Total latency: busy high for WIDTH+1 cycles; the result is visible on hi/lo from the cycle after E33.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product (signed or unsigned).
  - DIV/DIVU: lo = quotient, hi = remainder, truncating toward zero. Quotient is negative iff operand signs differ; remainder takes the dividend's sign.
  - Divide by zero (DIV or DIVU): lo = all ones, hi = operand_a as latched (raw, unsigned). Full latency still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- While busy:
  - start is ignored and no re-latch occurs; the hazard unit must stall.
  - mthi_en/mtlo_en are ignored.
- abort: when busy, at the next edge go to IDLE, busy=0, done=0; hi/lo keep their pre-operation values. abort in IDLE has no effect. If abort and start are both asserted in IDLE, start wins.
- Operand changes after E0 have no effect.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (−7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678 after the full 33-cycle latency.
- mtlo 0xAAAA5555 in IDLE, then MULTU 3 × 5. Mid-operation (cycle 10): assert start with new operands plus mthi_en -> both ignored; result hi=0, lo=15. Then start MULTU 2 × 2 and abort at cycle 10 -> busy=0 next cycle, no done pulse, hi/lo still 0/15.
- Start DIV, assert reset at cycle 20 -> hi=lo=0, busy=done=0 immediately. After release, a new DIVU 9 / 3 completes normally: lo=3, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with MTHI/MTLO writes.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             abort,
   input  logic             mthi_en,
   input  logic             mtlo_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t               state, state_next;
   logic [CNT_W-1:0]     count;
   logic                 is_div;
   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     mag_a, mag_b, raw_a;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     rem;

   logic                 latch_en, iter_en, fin_write, mt_en;
   logic                 in_signed, in_sign_a, in_sign_b;
   logic [WIDTH-1:0]     in_mag_a, in_mag_b;
   logic [WIDTH:0]       mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0]   mul_res;
   logic [WIDTH-1:0]     quo, rmd, res_hi, res_lo;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC: begin
            if (abort)              state_next = IDLE;
            else if (count == LAST) state_next = FIN;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy      = (state != IDLE);
      latch_en  = (state == IDLE) && start;
      mt_en     = (state == IDLE) && !start;
      iter_en   = (state == CALC) && !abort;
      fin_write = (state == FIN) && !abort;
   end

   // Operand magnitudes and sign flags at issue; unsigned ops never set a sign flag
   always_comb begin
      in_signed = ~op[0];
      in_sign_a = in_signed & operand_a[WIDTH-1];
      in_sign_b = in_signed & operand_b[WIDTH-1];
      in_mag_a  = in_sign_a ? -operand_a : operand_a;
      in_mag_b  = in_sign_b ? -operand_b : operand_b;
   end

   // One iteration of each algorithm; divide keeps the dividend/quotient in acc's low half
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      div_shift = {rem, acc[WIDTH-1]};
      div_trial = div_shift - {1'b0, mag_b};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         raw_a  <= '0;
         acc    <= '0;
         rem    <= '0;
      end else if (latch_en) begin
         count  <= '0;
         is_div <= op[1];
         sign_a <= in_sign_a;
         sign_b <= in_sign_b;
         mag_a  <= in_mag_a;
         mag_b  <= in_mag_b;
         raw_a  <= operand_a;
         acc    <= op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
         rem    <= '0;
      end else if (iter_en) begin
         count <= count + CNT_W'(1);
         if (is_div) begin
            if (div_trial[WIDTH]) begin
               rem <= div_shift[WIDTH-1:0];
               acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end else begin
               rem <= div_trial[WIDTH-1:0];
               acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end
         end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
         end
      end
   end

   // Sign correction; divide-by-zero overrides with all-ones quotient and raw dividend
   always_comb begin
      mul_res = (sign_a ^ sign_b) ? -acc : acc;
      quo     = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rmd     = sign_a ? -rem : rem;
      if (!is_div) begin
         res_hi = mul_res[2*WIDTH-1:WIDTH];
         res_lo = mul_res[WIDTH-1:0];
      end else if (mag_b == '0) begin
         res_hi = raw_a;
         res_lo = '1;
      end else begin
         res_hi = rmd;
         res_lo = quo;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= fin_write;
         if (fin_write) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (mt_en) begin
            if (mthi_en) hi <= wr_data;
            if (mtlo_en) lo <= wr_data;
         end
      end
   end

endmodule
